z3_cycle_initiator: RTL
=======================

# z3_cycle_initiator

Zorro III bus-master cycle engine: converts one local-bus cycle from the SCSI controller (address strobe, direction, SIZ, address, data) into a complete Zorro III master cycle on the expansion bus, then returns a single-clock STERM_n termination to the local master. It is the initiator counterpart to the board's Zorro slave path. It runs on the 25 MHz board clock and sits behind the arbiter. It only starts cycles while BMASTER is high, and the top level gates its bus drivers with BMASTER.

## Interface
Parameters:
- TIMEOUT, 255: clocks in WAIT without DTACK before a forced bus-error termination (8-bit counter).

Ports:
- CLK  in  1  25 MHz board clock; all state changes on rising edge.
- RESET_n  in  1  reset, asynchronous, active-low.
- BMASTER  in  1  board owns the Zorro bus.
- LAS_n  in  1  local address strobe, low = cycle request.
- LREAD  in  1  local direction, 1 = read.
- LSIZ  in  2  transfer size: 00 = 4 bytes, 01 = 1, 10 = 2, 11 = 3.
- LA  in  32  local address.
- LDIN  in  32  local write data.
- LDOUT  out  32  read data latched at termination.
- STERM_n  out  1  local cycle termination, one-clock low pulse.
- LBERR  out  1  high alongside STERM_n when the cycle ended in error.
- Z_A  out  32  Zorro address.
- Z_AOE  out  1  address drive enable.
- Z_FCS_n  out  1  Zorro full cycle strobe.
- Z_DS_n  out  4  Zorro data strobes; DS_n[3] = D31:24.
- Z_READ  out  1  Zorro READ.
- Z_DOE  out  1  data output enable.
- Z_DOUT  out  32  write data to the bus.
- Z_DIN  in  32  read data from the bus.
- Z_DTACK_n  in  1  target acknowledge (asynchronous).
- Z_BERR_n  in  1  bus error (asynchronous).

## Operation
- Z_DTACK_n and Z_BERR_n pass through two-flop synchronizers. All decisions use the synchronized values dtack_s and berr_s.
- States: IDLE, ADDR, STRB, DATA, WAIT, TERM, RECOVER.
- IDLE: when BMASTER=1 and LAS_n=0:
  - latch LA into Z_A, LDIN into Z_DOUT, LREAD into Z_READ, and compute the lane mask;
  - go to ADDR.
  - With BMASTER=0, LAS_n is ignored.
- ADDR: Z_AOE=1, Z_FCS_n=1. This is the address setup clock. Go to STRB.
- STRB: Z_FCS_n=0. Go to DATA.
- DATA: drive Z_DS_n to the inverted lane mask and set Z_DOE=1 (for both reads and writes). Go to WAIT.
- WAIT: count clocks.
  - berr_s=0 → TERM with error.
  - else dtack_s=0 → TERM normal.
  - else counter reaching TIMEOUT → TERM with error.
  - If berr_s and dtack_s are both asserted in the same clock, the error takes priority.
- TERM, one clock:
  - STERM_n=0;
  - LBERR=1 if error;
  - on a normal read, LDOUT<=Z_DIN;
  - on an error, LDOUT is unchanged.
  - Go to RECOVER.
- RECOVER: Z_FCS_n=1, Z_DS_n=1111, Z_DOE=0, Z_AOE held.
  - When dtack_s=1, berr_s=1 and LAS_n=1: Z_AOE<=0 and go to IDLE.
- A berr_s assertion in STRB or DATA also goes directly to TERM with error.
- Lane mask: first lane f = LA[1:0], count n = LSIZ (00 → 4). Lane k is active for f ≤ k ≤ min(3, f+n-1). Lane k drives DS_n[3-k]. Bytes crossing the long-word boundary are dropped; the local master re-issues them via dynamic sizing.
- A BMASTER drop during a cycle is ignored; the cycle runs to RECOVER. A new cycle is not started until BMASTER=1.

## Timing
- Reset values (asynchronous):
  - state IDLE, Z_FCS_n=1, Z_DS_n=1111, Z_READ=1, Z_DOE=0, Z_AOE=0;
  - STERM_n=1, LBERR=0, LDOUT=0, Z_A=0, Z_DOUT=0, counter=0;
  - synchronizers preset to 1.
- Reset mid-cycle returns all of the above immediately. STERM_n is never issued for an aborted cycle.
- Clock numbering, with LAS_n sampled low at edge 0:
  - Z_AOE rises after edge 1;
  - Z_FCS_n falls after edge 2;
  - Z_DS_n asserts after edge 3.
- Zero-wait target (Z_DTACK_n low before edge 3): dtack_s is seen in WAIT at edge 4 or later. STERM_n is low for exactly one clock, and never twice per cycle.
- Minimum initiator-to-STERM latency is 5 clocks. Minimum cycle-to-cycle spacing is 7 clocks.
- Z_DS_n and Z_DOE are deasserted no later than the clock after TERM. Z_FCS_n deasserts in the same clock as Z_DS_n.

## Test plan
- Long read, LA=0x40000000, LSIZ=00, target drives Z_DIN=0xDEADBEEF with DTACK 2 clocks after DS → DS_n=0000, one STERM_n pulse, LDOUT=0xDEADBEEF, LBERR=0, return to IDLE after DTACK release.
- Byte write, LA=0x40000003, LSIZ=01, LDIN=0x000000A5 → DS_n=1110, Z_READ=0, Z_DOUT=0x000000A5, Z_DOE=1 during DATA/WAIT.
- Lane sweep: word at LA[1:0]=01 → DS_n=1001; 3-byte at LA[1:0]=10 → DS_n=1100; long at LA[1:0]=11 → DS_n=1110.
- No DTACK: WAIT lasts TIMEOUT clocks, then STERM_n with LBERR=1, LDOUT unchanged.
- BERR and DTACK asserted in the same clock → LBERR=1, no LDOUT update. Separately, RESET_n pulsed low in WAIT → all outputs at reset values within the same clock, no STERM_n.
- BMASTER=0 with LAS_n=0 for 20 clocks → Z_AOE and Z_FCS_n stay idle. Raise BMASTER → cycle starts within 1 clock.

Source files
------------

// File: rtl/z3_cycle_initiator.sv
// Zorro III bus-master cycle engine: runs one local-bus cycle as a full
// Zorro III master cycle and returns a single-clock STERM_n to the local master.
module z3_cycle_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        BMASTER,
    input  logic        LAS_n,
    input  logic        LREAD,
    input  logic [1:0]  LSIZ,
    input  logic [31:0] LA,
    input  logic [31:0] LDIN,
    output logic [31:0] LDOUT,
    output logic        STERM_n,
    output logic        LBERR,
    output logic [31:0] Z_A,
    output logic        Z_AOE,
    output logic        Z_FCS_n,
    output logic [3:0]  Z_DS_n,
    output logic        Z_READ,
    output logic        Z_DOE,
    output logic [31:0] Z_DOUT,
    input  logic [31:0] Z_DIN,
    input  logic        Z_DTACK_n,
    input  logic        Z_BERR_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STRB,
        S_DATA,
        S_WAIT,
        S_TERM,
        S_RECOVER
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [3:0]  mask, mask_nxt;
    logic [31:0] ldout_nxt, za_nxt, zdout_nxt;
    logic        sterm_nxt, lberr_nxt, aoe_nxt, fcs_nxt;
    logic        read_nxt, doe_nxt;
    logic [3:0]  ds_nxt;
    logic        go_err;

    logic        dtack_q, dtack_s;
    logic        berr_q, berr_s;

    // Lane k (byte offset within the long word) maps to DS_n[3-k];
    // bytes past the long-word boundary are dropped.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] first,
        input logic [1:0] siz
    );
        logic [2:0] n;
        logic [2:0] last;
        logic [3:0] m;
        n    = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
        last = {1'b0, first} + n - 3'd1;
        m    = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            m[3-k] = (3'(k) >= {1'b0, first}) && (3'(k) <= last);
        end
        return m;
    endfunction

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            dtack_q <= 1'b1;
            dtack_s <= 1'b1;
            berr_q  <= 1'b1;
            berr_s  <= 1'b1;
        end else begin
            dtack_q <= Z_DTACK_n;
            dtack_s <= dtack_q;
            berr_q  <= Z_BERR_n;
            berr_s  <= berr_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            mask    <= 4'b0000;
            LDOUT   <= 32'd0;
            STERM_n <= 1'b1;
            LBERR   <= 1'b0;
            Z_A     <= 32'd0;
            Z_AOE   <= 1'b0;
            Z_FCS_n <= 1'b1;
            Z_DS_n  <= 4'b1111;
            Z_READ  <= 1'b1;
            Z_DOE   <= 1'b0;
            Z_DOUT  <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mask    <= mask_nxt;
            LDOUT   <= ldout_nxt;
            STERM_n <= sterm_nxt;
            LBERR   <= lberr_nxt;
            Z_A     <= za_nxt;
            Z_AOE   <= aoe_nxt;
            Z_FCS_n <= fcs_nxt;
            Z_DS_n  <= ds_nxt;
            Z_READ  <= read_nxt;
            Z_DOE   <= doe_nxt;
            Z_DOUT  <= zdout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        ldout_nxt = LDOUT;
        sterm_nxt = STERM_n;
        lberr_nxt = LBERR;
        za_nxt    = Z_A;
        aoe_nxt   = Z_AOE;
        fcs_nxt   = Z_FCS_n;
        ds_nxt    = Z_DS_n;
        read_nxt  = Z_READ;
        doe_nxt   = Z_DOE;
        zdout_nxt = Z_DOUT;
        go_err    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (BMASTER && !LAS_n) begin
                    za_nxt    = LA;
                    zdout_nxt = LDIN;
                    read_nxt  = LREAD;
                    mask_nxt  = lane_mask(LA[1:0], LSIZ);
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                aoe_nxt   = 1'b1;
                fcs_nxt   = 1'b1;
                state_nxt = S_STRB;
            end
            S_STRB: begin
                if (!berr_s) begin
                    go_err = 1'b1;
                end else begin
                    fcs_nxt   = 1'b0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (!berr_s) begin
                    go_err = 1'b1;
                end else begin
                    ds_nxt    = ~mask;
                    doe_nxt   = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!berr_s) begin
                    go_err = 1'b1;
                end else if (!dtack_s) begin
                    sterm_nxt = 1'b0;
                    lberr_nxt = 1'b0;
                    if (Z_READ) begin
                        ldout_nxt = Z_DIN;
                    end
                    state_nxt = S_TERM;
                end else if (cnt == CNT_LAST) begin
                    go_err = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_TERM: begin
                sterm_nxt = 1'b1;
                lberr_nxt = 1'b0;
                fcs_nxt   = 1'b1;
                ds_nxt    = 4'b1111;
                doe_nxt   = 1'b0;
                state_nxt = S_RECOVER;
            end
            S_RECOVER: begin
                // Hold the address until the target and local master both let go.
                if (dtack_s && berr_s && LAS_n) begin
                    aoe_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (go_err) begin
            sterm_nxt = 1'b0;
            lberr_nxt = 1'b1;
            state_nxt = S_TERM;
        end
    end

endmodule
